// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity checker: FSM state encoding and
// error-counter sizing.
package parity_pkg;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_PARITY  = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   localparam int                  ERRCNT_W   = 8;
   localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = 8'hFF;

endpackage

// File: rtl/parity_accum.sv
// Running XOR of accepted bits; cleared synchronously at frame end and
// asynchronously by reset.
module parity_accum (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic data_bit,
   output logic acc
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         acc <= 1'b0;
      else if (clr)
         acc <= 1'b0;
      else
         acc <= acc ^ (en & data_bit);
   end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial-to-parallel deserialiser with trailing parity check and valid/ready output.
// Optional saturating error counter enabled by defining PARITY_ERRCNT_EN.
module serial_parity_checker
   import parity_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_bit,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_err,
   output logic                 out_valid,
   input  logic                 out_ready
`ifdef PARITY_ERRCNT_EN
   ,
   output logic [ERRCNT_W-1:0]  err_count
`endif
);

   localparam int CNT_W = $clog2(DATA_BITS + 1);

   state_t               state;
   state_t               state_next;
   logic [CNT_W-1:0]     cnt;
   logic [DATA_BITS-1:0] sreg;
   logic                 acc;
   logic                 in_xfer;
   logic                 out_xfer;
   logic                 collect_xfer;
   logic                 parity_xfer;
   logic                 last_data;

   assign in_ready     = (state != ST_HOLD);
   assign in_xfer      = in_valid & in_ready;
   assign out_xfer     = out_valid & out_ready;
   assign collect_xfer = in_xfer && (state == ST_COLLECT);
   assign parity_xfer  = in_xfer && (state == ST_PARITY);
   assign last_data    = (cnt == CNT_W'(DATA_BITS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_COLLECT;
      else
         state <= state_next;
   end

   // NOTE: next state defaults to the current state first so no path infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         ST_COLLECT: if (in_xfer && last_data) state_next = ST_PARITY;
         ST_PARITY:  if (in_xfer)              state_next = ST_HOLD;
         ST_HOLD:    if (out_xfer)             state_next = ST_COLLECT;
         default:                              state_next = ST_COLLECT;
      endcase
   end

   parity_accum u_accum (
      .clk      (clk),
      .reset    (reset),
      .clr      (out_xfer),
      .en       (collect_xfer),
      .data_bit (in_bit),
      .acc      (acc)
   );

   // Each data bit lands at its own index, so the word comes out LSB-first ordered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         sreg      <= '0;
         out_data  <= '0;
         out_err   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (collect_xfer) begin
            for (int i = 0; i < DATA_BITS; i++)
               if (cnt == CNT_W'(i)) sreg[i] <= in_bit;
            cnt <= cnt + CNT_W'(1);
         end
         if (parity_xfer) begin
            out_err   <= acc ^ in_bit ^ ODD_PARITY;
            out_data  <= sreg;
            out_valid <= 1'b1;
         end
         if (out_xfer) begin
            out_valid <= 1'b0;
            cnt       <= '0;
         end
      end
   end

`ifdef PARITY_ERRCNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_count <= '0;
      else if (out_xfer && out_err && (err_count != ERRCNT_MAX))
         err_count <= err_count + ERRCNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even and odd instances share one stimulus stream;
// expected words/flags come from a bit-count reference model.
module tb_serial_parity_checker;

   localparam int DB = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_bit;
   logic          in_valid;
   logic          out_ready;
   logic          in_ready_e, out_err_e, out_valid_e;
   logic          in_ready_o, out_err_o, out_valid_o;
   logic [DB-1:0] out_data_e, out_data_o;
`ifdef PARITY_ERRCNT_EN
   logic [7:0]    err_count_e, err_count_o;
`endif

   int passed = 0;
   int total  = 0;
   int exp_cnt_e = 0;
   int exp_cnt_o = 0;
   logic          cur_err_e;
   logic [DB-1:0] cur_word;

   always #5 clk = ~clk;

   serial_parity_checker #(.DATA_BITS(DB), .ODD_PARITY(1'b0)) u_even (
      .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
      .in_ready(in_ready_e), .out_data(out_data_e), .out_err(out_err_e),
      .out_valid(out_valid_e), .out_ready(out_ready)
`ifdef PARITY_ERRCNT_EN
      , .err_count(err_count_e)
`endif
   );

   serial_parity_checker #(.DATA_BITS(DB), .ODD_PARITY(1'b1)) u_odd (
      .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
      .in_ready(in_ready_o), .out_data(out_data_o), .out_err(out_err_o),
      .out_valid(out_valid_o), .out_ready(out_ready)
`ifdef PARITY_ERRCNT_EN
      , .err_count(err_count_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Even-parity frame is bad when the total count of ones (data + parity) is odd.
   function automatic logic bad_even(input logic [DB-1:0] w, input logic p);
      return ((($countones(w) + int'(p)) % 2) != 0);
   endfunction

   task automatic send_frame(input logic [DB-1:0] w, input logic p, input bit bubbles);
      for (int i = 0; i <= DB; i++) begin
         if (bubbles) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_bit   = 1'($urandom);
         end
         @(negedge clk);
         check("in_ready_collect", 32'(in_ready_e), 1);
         in_valid = 1'b1;
         in_bit   = (i < DB) ? w[i] : p;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      in_bit    = 1'($urandom);
      cur_word  = w;
      cur_err_e = bad_even(w, p);
      check("out_valid_e", 32'(out_valid_e), 1);
      check("out_valid_o", 32'(out_valid_o), 1);
      check("out_data_e",  32'(out_data_e), 32'(w));
      check("out_data_o",  32'(out_data_o), 32'(w));
      check("out_err_e",   32'(out_err_e), 32'(cur_err_e));
      check("out_err_o",   32'(out_err_o), 32'(!cur_err_e));
      check("in_ready_hold", 32'(in_ready_e), 0);
   endtask

   task automatic consume();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (cur_err_e) exp_cnt_e = (exp_cnt_e < 255) ? exp_cnt_e + 1 : 255;
      else           exp_cnt_o = (exp_cnt_o < 255) ? exp_cnt_o + 1 : 255;
      check("out_valid_drop_e", 32'(out_valid_e), 0);
      check("out_valid_drop_o", 32'(out_valid_o), 0);
      check("in_ready_release", 32'(in_ready_e), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DB-1:0] w;
      logic          p;

      reset     = 1'b1;
      in_bit    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid_e), 0);
      check("rst_out_data",  32'(out_data_e), 0);
      check("rst_out_err",   32'(out_err_e), 0);
      check("rst_in_ready",  32'(in_ready_e), 1);
`ifdef PARITY_ERRCNT_EN
      check("rst_err_count", 32'(err_count_e), 0);
`endif
      reset = 1'b0;

      // Good even frame, then bad even frame (good for the odd instance).
      send_frame(8'hA5, 1'b0, 1'b0);
      consume();
      send_frame(8'h01, 1'b0, 1'b0);
      consume();

      // Backpressure: result held, input blocked even with in_valid asserted.
      send_frame(8'h5A, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_bit   = 1'($urandom);
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid_e), 1);
         check("bp_out_data",  32'(out_data_e), 32'h5A);
         check("bp_out_err",   32'(out_err_e), 1);
         check("bp_in_ready",  32'(in_ready_e), 0);
      end
      consume();

      // Bubbles between every bit.
      send_frame(8'h3C, 1'b0, 1'b1);
      consume();

      // Reset mid-frame after four bits, asserted between clock edges.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_bit   = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("midrst_out_data",  32'(out_data_e), 0);
      check("midrst_out_valid", 32'(out_valid_e), 0);
      check("midrst_in_ready",  32'(in_ready_e), 1);
      exp_cnt_e = 0;
      exp_cnt_o = 0;
      @(negedge clk);
      reset = 1'b0;
      send_frame(8'hFF, 1'b0, 1'b0);
      consume();

      // Randomised frames against the reference model.
      for (int n = 0; n < 20; n++) begin
         w = DB'($urandom);
         p = 1'($urandom);
         send_frame(w, p, 1'($urandom));
         consume();
      end

`ifdef PARITY_ERRCNT_EN
      check("cnt_mid_e", 32'(err_count_e), 32'(exp_cnt_e));
      check("cnt_mid_o", 32'(err_count_o), 32'(exp_cnt_o));
      for (int n = 0; n < 300; n++) begin
         w = DB'($urandom);
         p = 1'(($countones(w) + 1) % 2);
         send_frame(w, p, 1'b0);
         consume();
      end
      check("cnt_sat_e", 32'(err_count_e), 255);
      check("cnt_sat_o", 32'(err_count_o), 32'(exp_cnt_o));
      send_frame(8'h0F, 1'b0, 1'b0);
      consume();
      check("cnt_good_e", 32'(err_count_e), 255);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
